// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks an SPR_W x SPR_H sprite in ROM, drops key-coloured and
// off-screen texels, and writes the rest into the frame buffer over we/ready.
module sprite_blit_engine #(
   parameter int          SPR_W     = 32,
   parameter int          SPR_H     = 32,
   parameter int          SCREEN_W  = 640,
   parameter int          SCREEN_H  = 480,
   parameter logic [23:0] KEY_COLOR = 24'hFFFFFF,
   parameter int          ROM_BASE  = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   output logic [18:0] read_address,
   input  logic [23:0] rom_data,
   output logic [18:0] fb_addr,
   output logic [23:0] fb_data,
   output logic        fb_we,
   input  logic        fb_ready,
   output logic        busy,
   output logic        done
);

   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   typedef enum logic [2:0] {IDLE, ADDR, CAPT, WRITE, DONE} state_t;

   state_t        state, nxt;
   logic [9:0]    x0, y0;
   logic [CW-1:0] col, ncol;
   logic [RW-1:0] row, nrow;
   logic [10:0]   px, py;
   logic          last, skip, adv;

   assign last = (row == RW'(SPR_H - 1)) && (col == CW'(SPR_W - 1));
   assign px   = 11'(x0) + 11'(col);
   assign py   = 11'(y0) + 11'(row);
   assign skip = (rom_data == KEY_COLOR) || (px >= 11'(SCREEN_W)) || (py >= 11'(SCREEN_H));
   assign adv  = ((state == CAPT) && skip) || ((state == WRITE) && fb_ready);

   always_comb begin
      ncol = col + 1'b1;
      nrow = row;
      if (col == CW'(SPR_W - 1)) begin
         ncol = '0;
         nrow = row + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = ADDR;
         ADDR:    nxt = CAPT;
         CAPT:    if (!skip) nxt = WRITE;
                  else       nxt = last ? DONE : ADDR;
         WRITE:   if (fb_ready) nxt = last ? DONE : ADDR;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      done  = (state == DONE);
      fb_we = (state == WRITE);
   end

   // read_address is loaded on the edge entering ADDR so the ROM sees it for
   // the whole ADDR cycle and returns data in CAPT; it stays put until advance.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         x0           <= '0;
         y0           <= '0;
         row          <= '0;
         col          <= '0;
         read_address <= '0;
         fb_addr      <= '0;
         fb_data      <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            x0           <= sprite_x;
            y0           <= sprite_y;
            row          <= '0;
            col          <= '0;
            read_address <= 19'(ROM_BASE);
         end
         if ((state == CAPT) && !skip) begin
            fb_addr <= 19'(py) * 19'(SCREEN_W) + 19'(px);
            fb_data <= rom_data;
         end
         if (adv && !last) begin
            col          <= ncol;
            row          <= nrow;
            read_address <= 19'(ROM_BASE) + 19'(nrow) * 19'(SPR_W) + 19'(ncol);
         end
      end
   end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomized bench for sprite_blit_engine: ROM model, expected-write queue
// built from sprite contents and position, cycle-count and handshake checks.
module tb_sprite_blit_engine;

   localparam logic [23:0] KEY = 24'hFFFFFF;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  sprite_x = '0;
   logic [9:0]  sprite_y = '0;
   logic [18:0] read_address;
   logic [23:0] rom_data = '0;
   logic [18:0] fb_addr;
   logic [23:0] fb_data;
   logic        fb_we;
   logic        fb_ready = 1'b1;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   logic [23:0] rom [1024];

   typedef struct {
      int addr;
      int data;
      int ra;
   } wr_t;
   wr_t expq[$];

   always #5 Clk = ~Clk;

   always @(posedge Clk) rom_data <= rom[int'(read_address) % 1024];

   sprite_blit_engine dut (
      .Clk(Clk), .Reset(Reset), .start(start),
      .sprite_x(sprite_x), .sprite_y(sprite_y),
      .read_address(read_address), .rom_data(rom_data),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read_address"}, 32'(read_address), 0);
      chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
      chk({tag, "_fb_data"}, 32'(fb_data), 0);
      chk({tag, "_fb_we"}, 32'(fb_we), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
   endtask

   // pat: 0 opaque, 1 all key, 2 checkerboard, 3 random mix
   // rmode: 0 ready always, 1 random ready, 2 first write stalled 5 cycles
   task automatic run_sprite(input string tag, input int x, input int y, input int pat,
                             input int rmode, input bit mid, input int abort_at);
      int nw = 0, ns = 0, stalls = 0, busy_cnt = 0, writes = 0, we_first = 0, cyc = 0;
      int extra_done = 0;
      bit held = 0, got_done = 0, rdy;
      logic [31:0] h_addr = 0, h_data = 0, h_ra = 0;
      logic [23:0] c;
      wr_t w;

      for (int i = 0; i < 1024; i++) begin
         c = 24'($urandom);
         if (c == KEY) c = 24'h0;
         case (pat)
            1:       rom[i] = KEY;
            2:       rom[i] = (((i / 32) + (i % 32)) % 2 == 1) ? KEY : 24'h000000;
            3:       rom[i] = ($urandom_range(0, 3) == 0) ? KEY : c;
            default: rom[i] = c;
         endcase
      end

      expq.delete();
      for (int r = 0; r < 32; r++)
         for (int k = 0; k < 32; k++) begin
            if (rom[r*32+k] != KEY && x + k < 640 && y + r < 480) begin
               expq.push_back('{(y + r) * 640 + x + k, int'(rom[r*32+k]), r * 32 + k});
               nw++;
            end else ns++;
         end

      @(negedge Clk);
      sprite_x = 10'(x);
      sprite_y = 10'(y);
      start    = 1'b1;
      fb_ready = 1'b1;

      while (!got_done && cyc < 12000) begin
         @(negedge Clk);
         cyc++;
         start = mid && (cyc == 500);
         if (start) begin
            sprite_x = 10'($urandom);
            sprite_y = 10'($urandom_range(0, 479));
         end
         if (busy) busy_cnt++;
         if (fb_we) begin
            if (!held) begin
               held = 1;
               h_addr = 32'(fb_addr);
               h_data = 32'(fb_data);
               h_ra   = 32'(read_address);
            end else begin
               chk({tag, "_hold_addr"}, 32'(fb_addr), h_addr);
               chk({tag, "_hold_data"}, 32'(fb_data), h_data);
               chk({tag, "_hold_raddr"}, 32'(read_address), h_ra);
            end
            if (writes == 0) we_first++;
            case (rmode)
               1:       rdy = ($urandom_range(0, 3) != 0);
               2:       rdy = (writes > 0) || (we_first > 5);
               default: rdy = 1;
            endcase
            fb_ready = rdy;
            if (!rdy) stalls++;
            else begin
               held = 0;
               if (expq.size() == 0) chk({tag, "_extra_write"}, 1, 0);
               else begin
                  w = expq.pop_front();
                  chk({tag, "_fb_addr"}, 32'(fb_addr), w.addr);
                  chk({tag, "_fb_data"}, 32'(fb_data), w.data);
                  chk({tag, "_read_address"}, 32'(read_address), w.ra);
               end
               writes++;
               if (writes == abort_at) begin
                  Reset = 1'b0;
                  @(negedge Clk);
                  chk_all_zero({tag, "_abort"});
                  Reset    = 1'b0;
                  Reset    = 1'b1;
                  fb_ready = 1'b1;
                  return;
               end
            end
         end else begin
            fb_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (done) got_done = 1;
      end

      chk({tag, "_done_seen"}, 32'(got_done), 1);
      chk({tag, "_n_writes"}, writes, nw);
      chk({tag, "_busy_cycles"}, busy_cnt, 3 * nw + 2 * ns + 1 + stalls);
      if (rmode == 2) chk({tag, "_first_we_cycles"}, we_first, 6);
      start    = 1'b0;
      fb_ready = 1'b1;
      @(negedge Clk);
      chk({tag, "_busy_after_done"}, 32'(busy), 0);
      for (int i = 0; i < 10; i++) begin
         if (done) extra_done++;
         @(negedge Clk);
      end
      chk({tag, "_single_done"}, extra_done, 0);
   endtask

   initial begin
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      chk_all_zero("reset");
      Reset = 1'b1;
      @(negedge Clk);
      chk("idle_busy", 32'(busy), 0);

      run_sprite("opaque00", 0, 0, 0, 0, 0, -1);
      run_sprite("allkey", 100, 100, 1, 0, 0, -1);
      run_sprite("corner", 620, 470, 0, 0, 0, -1);
      run_sprite("stall", 10, 20, 0, 2, 0, -1);
      run_sprite("midstart", 200, 150, 3, 1, 1, -1);
      run_sprite("abort", 0, 0, 0, 0, 0, 300);
      run_sprite("restart", 0, 0, 0, 0, 0, -1);
      run_sprite("checker", 5, 5, 2, 0, 0, -1);
      for (int k = 0; k < 3; k++)
         run_sprite("random", $urandom_range(0, 700), $urandom_range(0, 520), 3, 1, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
- Read-side master for the single-sprite frame ROMs (1024-entry, 24-bit palette output, one-cycle registered read latency).
- On start, walks every texel of one SPR_W x SPR_H sprite, drives the ROM read address, and captures the returned colour.
- Drops key-coloured (transparent) and off-screen texels; writes the rest into the 640x480 frame buffer over a we/ready handshake.
- Sits between the game-state logic (issues start plus position) and the frame-buffer write port.

Parameters:
- SPR_W, 32, sprite width in texels
- SPR_H, 32, sprite height in texels
- SCREEN_W, 640, frame width in pixels
- SCREEN_H, 480, frame height in pixels
- KEY_COLOR, 24'hFFFFFF, transparent colour; never written
- ROM_BASE, 0, ROM address of texel (0,0)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; honoured only when idle
- sprite_x  in  10  screen column of texel (0,0); sampled on accepted start
- sprite_y  in  10  screen row of texel (0,0); sampled on accepted start
- read_address  out  19  ROM read address
- rom_data  in  24  ROM data_Out; valid one cycle after read_address is presented
- fb_addr  out  19  frame-buffer word address, y*SCREEN_W + x
- fb_data  out  24  pixel colour
- fb_we  out  1  write request
- fb_ready  in  1  frame buffer accepts the write this cycle
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at end of sprite

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - state goes to IDLE; texel counters row and col go to 0.
  - All outputs go to 0: read_address, fb_addr, fb_data, fb_we, busy, done.
  - Reset overrides any in-progress sprite; no partial write is held.
- States: IDLE, ADDR, CAPT, WRITE, DONE.
- IDLE:
  - With start=1: latch sprite_x and sprite_y; row=col=0; go to ADDR.
  - With start=0: stay.
- ADDR:
  - read_address = ROM_BASE + row*SPR_W + col (registered, stable through CAPT).
  - Next state is CAPT.
- CAPT: rom_data is valid this cycle. Compute px = x0+col and py = y0+row, 11-bit unsigned.
  - Skip when rom_data==KEY_COLOR, px>=SCREEN_W, or py>=SCREEN_H: advance, no write.
  - Otherwise register fb_addr = py*SCREEN_W+px (19-bit) and fb_data = rom_data; set fb_we=1; go to WRITE.
- WRITE:
  - fb_we, fb_addr, fb_data and read_address are held stable while fb_ready=0.
  - On an edge with fb_ready=1: fb_we drops to 0 and advance.
- Advance:
  - If row==SPR_H-1 and col==SPR_W-1: go to DONE.
  - Else col+1, wrapping to 0 with row+1 at col==SPR_W-1; go to ADDR.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy is 0 in IDLE only.
- start is ignored in every state except IDLE; it is not queued. sprite_x and sprite_y changes mid-sprite have no effect.
- Timing:
  - Written pixel: 3 cycles minimum (ADDR, CAPT, WRITE with ready); each ready=0 cycle adds 1.
  - Skipped pixel: 2 cycles.
- Scan order is row-major, row 0 first. fb writes emerge in that order.

Test Plan:
- All-opaque sprite (no KEY_COLOR), start at (0,0), fb_ready=1 -> exactly 1024 writes. Write n has fb_addr=(n/32)*640+(n%32) and fb_data equal to the ROM colour. done pulses 3073 cycles after start; busy high for 3073 cycles.
- All-KEY_COLOR sprite at (100,100) -> zero fb_we cycles. done pulses after 2049 busy cycles.
- Opaque sprite at (620,470) -> 200 writes (cols 0..19, rows 0..9). First fb_addr=470*640+620=301420, last=307199. No fb_addr exceeds 307199.
- fb_ready held low 5 cycles on the first write at (10,20) -> fb_we=1 for 6 cycles. fb_addr=12810 and fb_data stable throughout; read_address unchanged; pixel count still 1024.
- start pulsed mid-sprite -> ignored, single done. Reset=0 at pixel 300 -> next cycle all outputs 0 and busy=0. A following start at (0,0) writes from fb_addr 0 again.
- Checkerboard sprite (alternate 24'h000000 / KEY_COLOR) -> 512 writes, all fb_data=24'h000000. done high exactly one cycle.
